// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequential front end for external_memory. Accepts one load/store at a
//   time over start/ready/done, probes the access-fault check before any side
//   effect, issues exactly one enabled memory access, and returns size-masked,
//   optionally sign-extended read data with a fault code.
//
//   Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN
//     defined   -> misaligned half/word requests fault with type 10
//     undefined -> no alignment check, misaligned addresses go to memory as-is
//
// Ports
//   clk, reset                 clock, async active-high reset
//   start / ready / done       request handshake (done is a 1-cycle pulse)
//   is_write, op_size,
//   is_signed, addr,
//   write_data                 request fields, sampled when start & ready
//   read_data, fault,
//   fault_type                 response, valid only while done=1 (0 otherwise)
//   mem_enable, mem_is_write,
//   mem_op_size, mem_addr,
//   mem_in                     request to external_memory (0 in IDLE)
//   mem_out, mem_access_fault  combinational responses from external_memory
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic        is_write,
  input  logic [1:0]  op_size,
  input  logic        is_signed,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        done,
  output logic [31:0] read_data,
  output logic        fault,
  output logic [1:0]  fault_type,
  output logic        mem_enable,
  output logic        mem_is_write,
  output logic [1:0]  mem_op_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  input  logic        mem_access_fault
);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_is_write, r_is_signed;
  logic [1:0]  r_op_size;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_fault_type;
  logic [31:0] r_rdata;

  logic [1:0]  w_fault_type;
  logic [31:0] w_wdata_masked;
  logic [31:0] w_load_data;
  logic        w_active;

  // Priority: invalid size, then misalignment (optional), then access fault.
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = (r_op_size == 2'b01 && r_addr[0]) ||
                      (r_op_size == 2'b10 && r_addr[1:0] != 2'b00);
  always_comb begin
    w_fault_type = 2'b00;
    if (r_op_size == 2'b11)  w_fault_type = 2'b11;
    else if (w_misalign)     w_fault_type = 2'b10;
    else if (mem_access_fault) w_fault_type = 2'b01;
  end
`else
  always_comb begin
    w_fault_type = 2'b00;
    if (r_op_size == 2'b11)  w_fault_type = 2'b11;
    else if (mem_access_fault) w_fault_type = 2'b01;
  end
`endif

  always_comb begin
    case (r_op_size)
      2'b00:   w_wdata_masked = {24'b0, r_wdata[7:0]};
      2'b01:   w_wdata_masked = {16'b0, r_wdata[15:0]};
      default: w_wdata_masked = r_wdata;
    endcase
  end

  always_comb begin
    case (r_op_size)
      2'b00:   w_load_data = r_is_signed ? {{24{mem_out[7]}}, mem_out[7:0]}
                                         : {24'b0, mem_out[7:0]};
      2'b01:   w_load_data = r_is_signed ? {{16{mem_out[15]}}, mem_out[15:0]}
                                         : {16'b0, mem_out[15:0]};
      default: w_load_data = mem_out;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake/enable outputs
  always_comb begin
    w_next     = r_state;
    ready      = 1'b0;
    done       = 1'b0;
    mem_enable = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_next = CHECK;
      end
      CHECK:   w_next = (w_fault_type != 2'b00) ? RESP : ISSUE;
      ISSUE: begin
        mem_enable = 1'b1;
        w_next     = RESP;
      end
      default: begin
        done   = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

  // Request latch and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write   <= 1'b0;
      r_is_signed  <= 1'b0;
      r_op_size    <= 2'b00;
      r_addr       <= 32'b0;
      r_wdata      <= 32'b0;
      r_fault_type <= 2'b00;
      r_rdata      <= 32'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_is_write  <= is_write;
          r_is_signed <= is_signed;
          r_op_size   <= op_size;
          r_addr      <= addr;
          r_wdata     <= write_data;
        end
        CHECK: begin
          r_fault_type <= w_fault_type;
          r_rdata      <= 32'b0;
        end
        ISSUE: r_rdata <= r_is_write ? 32'b0 : w_load_data;
        default: ;
      endcase
    end
  end

  assign w_active     = (r_state != IDLE);
  assign mem_is_write = w_active & r_is_write;
  assign mem_op_size  = w_active ? r_op_size : 2'b00;
  assign mem_addr     = w_active ? r_addr : 32'b0;
  assign mem_in       = w_active ? w_wdata_masked : 32'b0;

  assign fault_type = done ? r_fault_type : 2'b00;
  assign fault      = done & (r_fault_type != 2'b00);
  assign read_data  = done ? r_rdata : 32'b0;

endmodule
